glb_bank_sram_ctrl: RTL and testbench

- Request-side controller directly upstream of glb_bank_sram_gen in each GLB bank.
- Accepts independent write and read request streams (valid/ready), arbitrates them onto the single-port SRAM interface (active-low CEB/WEB/BWEB), and expands byte strobes into bit write-enables.
- Tracks in-flight reads through the fixed SRAM latency and returns read data with its tag through a credit-protected response FIFO.

---
 rtl/glb_pkg.sv | 22 ++
 rtl/glb_rsp_fifo.sv | 69 ++++++
 rtl/glb_rsp_fifo_chk.sv | 19 +
 rtl/glb_bank_sram_ctrl.sv | 161 ++++++++++++++++
 tb/tb_glb_bank_sram_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_pkg.sv
// Shared constants and types for the GLB bank request-side controller.
package glb_pkg;

    localparam int GLB_SRAM_LATENCY    = 2;
    localparam int GLB_BANK_DATA_WIDTH = 64;
    localparam int GLB_BANK_ADDR_WIDTH = 14;
    localparam int GLB_RD_TAG_WIDTH    = 4;
    localparam int GLB_RSP_FIFO_DEPTH  = 4;

    // Side favoured by the round-robin pointer when both requesters contend.
    typedef enum logic {
        RR_WRITE = 1'b0,
        RR_READ  = 1'b1
    } rr_side_e;

    // One stage of the in-flight read tracker at the default tag width.
    typedef struct packed {
        logic                        valid;
        logic [GLB_RD_TAG_WIDTH-1:0] tag;
    } glb_rd_pipe_t;

endpackage

// File: rtl/glb_rsp_fifo.sv
// Synchronous FIFO with occupancy count; a pop on empty is ignored and a
// push while full is only taken when a pop frees the slot in the same cycle.
module glb_rsp_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Next-state: qualify push/pop, advance pointers (natural wrap), update count.
    always_comb begin
        pop_ok_s  = pop & (count_q != {CW{1'b0}});
        push_ok_s = push & ((count_q != CW'(DEPTH)) | pop_ok_s);
        mem_d     = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end

    // State registers; reset flushes contents and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == {CW{1'b0}});
    assign count    = count_q;

endmodule

// File: rtl/glb_rsp_fifo_chk.sv
// Safety properties on the response FIFO as used by the bank controller.
module glb_rsp_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          full,
    input logic [CW-1:0] count
);

    // Credits must keep the FIFO from ever being pushed while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

    // Occupancy can never exceed the physical depth.
    a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));

endmodule

// File: rtl/glb_bank_sram_ctrl.sv
// GLB bank request-side controller: arbitrates write/read requests onto the
// single-port SRAM, tracks reads through the SRAM latency and returns data
// with its tag through a credit-protected response FIFO.
module glb_bank_sram_ctrl
    import glb_pkg::*;
#(
    parameter int DATA_WIDTH     = GLB_BANK_DATA_WIDTH,
    parameter int ADDR_WIDTH     = GLB_BANK_ADDR_WIDTH,
    parameter int TAG_WIDTH      = GLB_RD_TAG_WIDTH,
    parameter int SRAM_LATENCY   = GLB_SRAM_LATENCY,
    parameter int RSP_FIFO_DEPTH = GLB_RSP_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_req_valid,
    output logic                      wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]     wr_req_addr,
    input  logic [DATA_WIDTH-1:0]     wr_req_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_req_strb,
    input  logic                      rd_req_valid,
    output logic                      rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]     rd_req_addr,
    input  logic [TAG_WIDTH-1:0]      rd_req_tag,
    output logic                      rd_rsp_valid,
    input  logic                      rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]     rd_rsp_data,
    output logic [TAG_WIDTH-1:0]      rd_rsp_tag,
    output logic                      sram_ceb,
    output logic                      sram_web,
    output logic [DATA_WIDTH-1:0]     sram_bweb,
    output logic [ADDR_WIDTH-1:0]     sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_d,
    input  logic [DATA_WIDTH-1:0]     sram_q
);

    localparam int CRW        = $clog2(RSP_FIFO_DEPTH) + 1;
    // Q is valid in the cycle after the SRAM_LATENCY-th edge, so the tag is
    // carried one extra stage to line up with the capture edge.
    localparam int PIPE_DEPTH = SRAM_LATENCY + 1;
    localparam int RSP_W      = DATA_WIDTH + TAG_WIDTH;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } rd_pipe_t;

    rr_side_e         rr_ptr_q, rr_ptr_d;
    logic [CRW-1:0]   credit_q, credit_d;
    rd_pipe_t         rd_pipe_q [PIPE_DEPTH];
    rd_pipe_t         rd_pipe_d [PIPE_DEPTH];

    logic             credit_ok_s;
    logic             contended_s;
    logic             wr_grant_s;
    logic             rd_grant_s;
    logic             pop_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CRW-1:0]   fifo_count_s;
    logic [RSP_W-1:0] fifo_head_s;

    // Arbitration, round-robin update and SRAM pin drive for the granted side.
    always_comb begin
        credit_ok_s  = (credit_q != {CRW{1'b0}});
        contended_s  = wr_req_valid & rd_req_valid & credit_ok_s;
        wr_req_ready = !reset & !(rd_req_valid & credit_ok_s & (rr_ptr_q == RR_READ));
        rd_req_ready = !reset & credit_ok_s & !(wr_req_valid & (rr_ptr_q == RR_WRITE));
        wr_grant_s   = wr_req_valid & wr_req_ready;
        rd_grant_s   = rd_req_valid & rd_req_ready;

        rr_ptr_d = rr_ptr_q;
        if (contended_s & (wr_grant_s | rd_grant_s)) begin
            rr_ptr_d = (rr_ptr_q == RR_WRITE) ? RR_READ : RR_WRITE;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = {DATA_WIDTH{1'b1}};
        sram_addr = {ADDR_WIDTH{1'b0}};
        sram_d    = {DATA_WIDTH{1'b0}};
        if (wr_grant_s) begin
            sram_ceb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = wr_req_addr;
            sram_d    = wr_req_data;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                sram_bweb[i] = ~wr_req_strb[i/8];
            end
        end else if (rd_grant_s) begin
            sram_ceb  = 1'b0;
            sram_addr = rd_req_addr;
        end else begin
            sram_ceb = 1'b1;
        end
    end

    // Credit accounting and in-flight read tracking.
    always_comb begin
        pop_s  = rd_rsp_valid & rd_rsp_ready;
        push_s = rd_pipe_q[PIPE_DEPTH-1].valid;
        case ({rd_grant_s, pop_s})
            2'b10:   credit_d = credit_q - {{(CRW-1){1'b0}}, 1'b1};
            2'b01:   credit_d = credit_q + {{(CRW-1){1'b0}}, 1'b1};
            default: credit_d = credit_q;
        endcase
        rd_pipe_d[0].valid = rd_grant_s;
        rd_pipe_d[0].tag   = rd_grant_s ? rd_req_tag : {TAG_WIDTH{1'b0}};
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    // Controller state; reset drops in-flight reads and restores all credits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= RR_WRITE;
            credit_q <= CRW'(RSP_FIFO_DEPTH);
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                rd_pipe_q[i] <= '{valid: 1'b0, tag: {TAG_WIDTH{1'b0}}};
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    glb_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({rd_pipe_q[PIPE_DEPTH-1].tag, sram_q}),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    glb_rsp_fifo_chk #(
        .DEPTH (RSP_FIFO_DEPTH),
        .CW    (CRW)
    ) u_rsp_fifo_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    assign rd_rsp_valid = !fifo_empty_s;
    assign rd_rsp_data  = fifo_empty_s ? {DATA_WIDTH{1'b0}} : fifo_head_s[DATA_WIDTH-1:0];
    assign rd_rsp_tag   = fifo_empty_s ? {TAG_WIDTH{1'b0}}  : fifo_head_s[RSP_W-1:DATA_WIDTH];

endmodule

// File: tb/tb_glb_bank_sram_ctrl.sv
// Directed bench for glb_bank_sram_ctrl with a behavioural SRAM model.
module tb_glb_bank_sram_ctrl;

    localparam int DW = 64;
    localparam int AW = 14;
    localparam int TW = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic [SW-1:0] wr_req_strb;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic [TW-1:0] rd_req_tag;
    logic          rd_rsp_valid, rd_rsp_ready;
    logic [DW-1:0] rd_rsp_data;
    logic [TW-1:0] rd_rsp_tag;
    logic          sram_ceb, sram_web;
    logic [DW-1:0] sram_bweb, sram_d, sram_q;
    logic [AW-1:0] sram_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    glb_bank_sram_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_strb  (wr_req_strb),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_req_tag   (rd_req_tag),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_tag   (rd_rsp_tag),
        .sram_ceb     (sram_ceb),
        .sram_web     (sram_web),
        .sram_bweb    (sram_bweb),
        .sram_addr    (sram_addr),
        .sram_d       (sram_d),
        .sram_q       (sram_q)
    );

    // SRAM model: inputs registered at the edge, Q valid after two more edges.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] s1_r, s2_r;
    always @(posedge clk) begin
        if (reset) begin
            s1_r   <= '0;
            s2_r   <= '0;
            sram_q <= '0;
        end else begin
            if (!sram_ceb) begin
                if (!sram_web) mem[sram_addr] <= (mem[sram_addr] & sram_bweb) | (sram_d & ~sram_bweb);
                else           s1_r <= mem[sram_addr];
            end
            s2_r   <= s1_r;
            sram_q <= s2_r;
        end
    end

    task automatic idle_inputs;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_tag  = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; idle_inputs(); rd_rsp_ready = 1'b1;
        wr_req_valid = 1'b1; rd_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (sram_ceb !== 1'b1) begin bad++; $display("FAIL rst_ceb got=%b want=1", sram_ceb); end
        total++; if (sram_bweb !== {DW{1'b1}}) begin bad++; $display("FAIL rst_bweb got=%h want=all1", sram_bweb); end
        total++; if (wr_req_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b want=0", wr_req_ready); end
        total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL rst_rd_ready got=%b want=0", rd_req_ready); end
        total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rd_rsp_valid); end
        total++; if (sram_addr !== '0 || sram_d !== '0) begin bad++; $display("FAIL rst_addr_d got=%h/%h want=0/0", sram_addr, sram_d); end
        @(negedge clk);
        reset = 1'b0; idle_inputs();
        #1;
        total++; if (wr_req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_wr_ready got=%b want=1", wr_req_ready); end
        total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_rd_ready got=%b want=1", rd_req_ready); end
        total++; if (sram_ceb !== 1'b1 || sram_web !== 1'b1) begin bad++; $display("FAIL idle_ceb_web got=%b%b want=11", sram_ceb, sram_web); end
    endtask

    task automatic test_contended;
        logic exp_w;
        rd_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_req_valid = 1'b1; wr_req_addr = 14'h0010 + 14'(k/2);
            wr_req_data  = 64'hA000_0000_0000_0000 | 64'(k/2); wr_req_strb = 8'hFF;
            rd_req_valid = 1'b1; rd_req_addr = 14'h0010 + 14'(k/2); rd_req_tag = 4'(k);
            #1;
            exp_w = ((k % 2) == 0);
            total++;
            if (sram_ceb !== 1'b0 || sram_web !== !exp_w || wr_req_ready !== exp_w || rd_req_ready !== !exp_w) begin
                bad++;
                $display("FAIL contend_k%0d got ceb=%b web=%b wrdy=%b rrdy=%b want ceb=0 web=%b wrdy=%b rrdy=%b",
                         k, sram_ceb, sram_web, wr_req_ready, rd_req_ready, !exp_w, exp_w, !exp_w);
            end
        end
        @(negedge clk); idle_inputs();
        @(negedge clk); #1;
        total++; if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 4'd1 || rd_rsp_data !== 64'hA000_0000_0000_0000) begin
            bad++; $display("FAIL contend_rsp1 got v=%b tag=%h data=%h want v=1 tag=1 data=a000000000000000", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
        @(negedge clk); #1;
        total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL contend_gap got v=%b want=0", rd_rsp_valid); end
        @(negedge clk); #1;
        total++; if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 4'd3 || rd_rsp_data !== 64'hA000_0000_0000_0001) begin
            bad++; $display("FAIL contend_rsp3 got v=%b tag=%h data=%h want v=1 tag=3 data=a000000000000001", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
        @(negedge clk); #1;
        total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL contend_drain got v=%b want=0", rd_rsp_valid); end
    endtask

    task automatic test_write_read;
        int waited;
        rd_rsp_ready = 1'b0;
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 14'h0805; wr_req_data = 64'hDEADBEEF_01234567; wr_req_strb = 8'h0F;
        #1;
        total++; if (sram_ceb !== 1'b0 || sram_web !== 1'b0 || wr_req_ready !== 1'b1) begin
            bad++; $display("FAIL wr_issue got ceb=%b web=%b rdy=%b want 0 0 1", sram_ceb, sram_web, wr_req_ready); end
        total++; if (sram_bweb !== 64'hFFFFFFFF_00000000) begin bad++; $display("FAIL wr_bweb got=%h want=ffffffff00000000", sram_bweb); end
        total++; if (sram_addr !== 14'h0805 || sram_d !== 64'hDEADBEEF_01234567) begin
            bad++; $display("FAIL wr_addr_d got=%h/%h want=0805/deadbeef01234567", sram_addr, sram_d); end
        @(negedge clk);
        idle_inputs(); rd_req_valid = 1'b1; rd_req_addr = 14'h0805; rd_req_tag = 4'd5;
        #1;
        total++; if (sram_ceb !== 1'b0 || sram_web !== 1'b1 || sram_bweb !== {DW{1'b1}} || rd_req_ready !== 1'b1) begin
            bad++; $display("FAIL rd_issue got ceb=%b web=%b bweb=%h rdy=%b want 0 1 all1 1", sram_ceb, sram_web, sram_bweb, rd_req_ready); end
        @(negedge clk); idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_c%0d got v=%b want=0", c, rd_rsp_valid); end
        end
        @(negedge clk); #1;
        total++; if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 4'd5 || rd_rsp_data[31:0] !== 32'h01234567) begin
            bad++; $display("FAIL rd_rsp got v=%b tag=%h lo=%h want v=1 tag=5 lo=01234567", rd_rsp_valid, rd_rsp_tag, rd_rsp_data[31:0]); end
        rd_rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_pop got v=%b want=0", rd_rsp_valid); end
        // Zero strobe still issues but changes nothing.
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 14'h0805; wr_req_data = '1; wr_req_strb = 8'h00;
        #1;
        total++; if (sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_bweb !== {DW{1'b1}}) begin
            bad++; $display("FAIL wr_zero_strb got ceb=%b web=%b bweb=%h want 0 0 all1", sram_ceb, sram_web, sram_bweb); end
        @(negedge clk);
        idle_inputs(); rd_req_valid = 1'b1; rd_req_addr = 14'h0805; rd_req_tag = 4'd6;
        @(negedge clk); idle_inputs(); #1;
        waited = 0;
        while (!rd_rsp_valid && waited < 10) begin @(negedge clk); #1; waited++; end
        total++; if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 4'd6 || rd_rsp_data[31:0] !== 32'h01234567) begin
            bad++; $display("FAIL rd_after_zero_strb got v=%b tag=%h lo=%h want v=1 tag=6 lo=01234567", rd_rsp_valid, rd_rsp_tag, rd_rsp_data[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int acc;
        int nrsp;
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_req_valid = 1'b1; wr_req_addr = 14'h0100 + 14'(i);
            wr_req_data  = 64'hC0DE_0000_0000_0000 | 64'(i); wr_req_strb = 8'hFF;
        end
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            idle_inputs(); rd_req_valid = 1'b1; rd_req_addr = 14'h0100 + 14'(acc); rd_req_tag = 4'(acc);
            #1;
            if (rd_req_ready) acc++;
        end
        total++; if (acc != 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", acc); end
        total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", rd_req_ready); end
        @(negedge clk);
        rd_rsp_ready = 1'b1; #1;
        // Pop this cycle frees a credit only from the next cycle on.
        total++; if (rd_req_ready !== 1'b0 || rd_rsp_valid !== 1'b1) begin
            bad++; $display("FAIL bp_pop_at_zero got rrdy=%b v=%b want 0 1", rd_req_ready, rd_rsp_valid); end
        nrsp = 0;
        for (int c = 0; c < 80 && nrsp < 10; c++) begin
            if (c == 1) begin
                total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL bp_credit_back got=%b want=1", rd_req_ready); end
            end
            if (rd_rsp_valid) begin
                total++;
                if (rd_rsp_tag !== 4'(nrsp) || rd_rsp_data !== (64'hC0DE_0000_0000_0000 | 64'(nrsp))) begin
                    bad++; $display("FAIL bp_rsp%0d got tag=%h data=%h want tag=%h data=%h", nrsp, rd_rsp_tag, rd_rsp_data,
                                    4'(nrsp), 64'hC0DE_0000_0000_0000 | 64'(nrsp));
                end
                nrsp++;
            end
            if (rd_req_valid && rd_req_ready) acc++;
            @(negedge clk);
            rd_req_valid = (acc < 10); rd_req_addr = 14'h0100 + 14'(acc); rd_req_tag = 4'(acc);
            #1;
        end
        idle_inputs();
        total++; if (nrsp != 10 || acc != 10) begin bad++; $display("FAIL bp_all_returned got rsp=%0d acc=%0d want 10 10", nrsp, acc); end
    endtask

    task automatic test_reset_inflight;
        int acc;
        rd_rsp_ready = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = 14'h0100; rd_req_tag = 4'hA; #1;
        total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL rif_rd0 got=%b want=1", rd_req_ready); end
        @(negedge clk);
        rd_req_addr = 14'h0101; rd_req_tag = 4'hB; #1;
        total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL rif_rd1 got=%b want=1", rd_req_ready); end
        @(negedge clk);
        idle_inputs(); reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rif_no_rsp_c%0d got v=%b tag=%h want v=0", c, rd_rsp_valid, rd_rsp_tag); end
            @(negedge clk);
        end
        rd_rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            rd_req_valid = 1'b1; rd_req_addr = 14'h0100; rd_req_tag = 4'(acc);
            #1;
            if (rd_req_ready) acc++;
            @(negedge clk);
        end
        total++; if (acc != 4) begin bad++; $display("FAIL rif_credits got=%0d want=4", acc); end
        idle_inputs(); rd_rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contended();
        test_write_read();
        test_backpressure();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
